// File: rtl/washer_panel_conditioner_if.sv
// washer_panel_conditioner_if: raw panel inputs and conditioned washer controls
interface washer_panel_conditioner_if;
  logic       start_btn;
  logic       door_sw;
  logic [1:0] load_sw;
  logic       busy;
  logic       Start;
  logic       Door;
  logic [1:0] load;
  logic       start_rejected;
  modport master (output start_btn, door_sw, load_sw, busy, input Start, Door, load, start_rejected);
  modport slave (input start_btn, door_sw, load_sw, busy, output Start, Door, load, start_rejected);
endinterface

// File: rtl/washer_panel_conditioner.sv
// washer_panel_conditioner: synchronise, debounce and condition front-panel inputs for washerTop
module washer_panel_conditioner #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input logic                       clk,
  input logic                       reset,
  washer_panel_conditioner_if.slave pnl
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);
  logic [3:0]       raw;
  logic [3:0]       sync1_q, sync2_q, stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic             prev_q, busy_q, start_q, rej_q;
  logic [1:0]       load_q;
  assign raw = {pnl.start_btn, pnl.door_sw, pnl.load_sw};
  // per-bit debounce: count consecutive disagreeing cycles, flip on the last one
  always_comb begin
    stable_d = stable_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      stable_d[i] = (sync2_q[i] != stable_q[i] && cnt_q[i] == LAST) ? ~stable_q[i] : stable_q[i];
      cnt_d[i] = (sync2_q[i] == stable_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + CNT_W'(1);
    end
  end
  // synchronisers, debounce state, start edge detect with busy captured at the rising edge, load hold
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      stable_q <= '0;
      cnt_q <= '{default: '0};
      prev_q <= 1'b0;
      busy_q <= 1'b0;
      start_q <= 1'b0;
      rej_q <= 1'b0;
      load_q <= 2'b00;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
      prev_q <= stable_q[3];
      busy_q <= pnl.busy;
      start_q <= stable_q[3] & ~prev_q & ~busy_q;
      rej_q <= stable_q[3] & ~prev_q & busy_q;
      load_q <= pnl.busy ? load_q : stable_q[1:0];
    end
  end
  assign pnl.Start = start_q;
  assign pnl.start_rejected = rej_q;
  assign pnl.Door = stable_q[2];
  assign pnl.load = load_q;
endmodule

// File: tb/tb_washer_panel_conditioner.sv
// tb_washer_panel_conditioner: directed stimulus against a sliding-window behavioural model
module tb_washer_panel_conditioner;
  localparam int DB = 4;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_err = 0;
  washer_panel_conditioner_if pnl ();
  washer_panel_conditioner #(.DB_CYCLES(DB), .CNT_W(8)) dut (.clk(clk), .reset(reset), .pnl(pnl));
  always #5 clk = ~clk;
  logic [3:0] hist [$];
  logic [3:0] m_stable, m_old, m_flip;
  logic       m_rise, m_bpend, m_start, m_rej;
  logic [1:0] m_load;
  bit         m_valid = 1'b0;
  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask
  // model: a stable bit flips when the last DB synchronised samples (raw delayed two edges) all disagree with it
  always @(posedge clk) begin
    m_valid = 1'b1;
    if (reset) begin
      hist = {};
      repeat (DB + 2) hist.push_back(4'b0);
      m_stable = '0;
      m_rise = 1'b0;
      m_bpend = 1'b0;
      m_start = 1'b0;
      m_rej = 1'b0;
      m_load = 2'b00;
    end else begin
      m_old = m_stable;
      hist.push_back({pnl.start_btn, pnl.door_sw, pnl.load_sw});
      if (hist.size() > DB + 2) void'(hist.pop_front());
      m_flip = 4'hF;
      for (int j = 0; j < DB; j++) m_flip &= hist[j] ^ m_old;
      m_stable = m_old ^ m_flip;
      m_start = m_rise & ~m_bpend;
      m_rej = m_rise & m_bpend;
      m_rise = m_stable[3] & ~m_old[3];
      m_bpend = pnl.busy;
      if (!pnl.busy) m_load = m_old[1:0];
    end
  end
  // every cycle: outputs against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_start", 2'(pnl.Start), 2'(m_start));
      chk("m_rej", 2'(pnl.start_rejected), 2'(m_rej));
      chk("m_door", 2'(pnl.Door), 2'(m_stable[2]));
      chk("m_load", pnl.load, m_load);
      chk("m_excl", 2'(pnl.Start & pnl.start_rejected), 2'b00);
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic watch_start(input int at, input int n, input logic rej);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      chk("start_t", 2'(pnl.Start), 2'(k == at && !rej));
      chk("rej_t", 2'(pnl.start_rejected), 2'(k == at && rej));
    end
  endtask
  task automatic watch_door(input int lo, input int hi, input int n);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      chk("door_t", 2'(pnl.Door), 2'(k >= lo && k < hi));
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1;
    pnl.start_btn = 1'b0;
    pnl.door_sw = 1'b0;
    pnl.load_sw = 2'b00;
    pnl.busy = 1'b0;
    step(10);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("rst_out", {pnl.Start | pnl.start_rejected, pnl.Door}, 2'b00);
      chk("rst_load", pnl.load, 2'b00);
    end
    pnl.start_btn = 1'b1;
    watch_start(7, 20, 1'b0);
    pnl.start_btn = 1'b0;
    watch_start(0, 10, 1'b0);
    for (int b = 0; b < 4; b++) begin
      pnl.start_btn = ~b[0];
      watch_start(0, 2, 1'b0);
    end
    pnl.start_btn = 1'b1;
    watch_start(7, 20, 1'b0);
    pnl.start_btn = 1'b0;
    step(10);
    pnl.busy = 1'b1;
    pnl.load_sw = 2'b10;
    step(10);
    chk("load_held", pnl.load, 2'b00);
    pnl.start_btn = 1'b1;
    watch_start(7, 12, 1'b1);
    chk("load_held2", pnl.load, 2'b00);
    pnl.busy = 1'b0;
    step(1);
    chk("load_release", pnl.load, 2'b10);
    pnl.start_btn = 1'b0;
    pnl.load_sw = 2'b11;
    step(10);
    chk("load_11", pnl.load, 2'b11);
    pnl.door_sw = 1'b1;
    watch_door(0, 0, 3);
    pnl.door_sw = 1'b0;
    watch_door(0, 0, 10);
    pnl.door_sw = 1'b1;
    watch_door(6, 99, 20);
    pnl.door_sw = 1'b0;
    watch_door(1, 6, 10);
    pnl.start_btn = 1'b1;
    watch_start(0, 3, 1'b0);
    reset = 1'b1;
    watch_start(0, 1, 1'b0);
    reset = 1'b0;
    watch_start(7, 15, 1'b0);
    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
